// File: rtl/spi_slave_trx_char_pkg.sv
// Shared definitions for the SPI target character transceiver: FSM states,
// SPI mode codes {CPOL,CPHA} and the character-length / bit-order helpers
// that the master side of the link uses as well.
package spi_slave_trx_char_pkg;

  // Frame sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // SPI mode codes, packed as {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  // Bit counters must hold 0..32
  localparam int CNT_W = 6;

  // Character length decode: 0 means 32 bits, otherwise len+1 bits
  function automatic logic [CNT_W-1:0] char_bits(input logic [3:0] len);
    logic [CNT_W-1:0] n;
    if (len == 4'd0) n = CNT_W'(32);
    else             n = {2'b00, len} + CNT_W'(1);
    return n;
  endfunction

  // Position in the character of serial bit number cnt (LSB-first or MSB-first)
  function automatic logic [CNT_W-1:0] bit_index(input logic             rev,
                                                 input logic [CNT_W-1:0] nbits,
                                                 input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] idx;
    if (rev) idx = nbits - cnt - CNT_W'(1);
    else     idx = cnt;
    return idx;
  endfunction

endpackage

// File: rtl/spi_slave_trx_char_pin_sync.sv
// Pin synchronizer: STAGES flops into the system clock plus one delay flop for edge detection.
// Latency: pin change visible on level after STAGES cycles; rise/fall strobe in that same cycle.
// Backpressure: none; strobes are single-cycle and must be consumed when raised.
module spi_slave_trx_char_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  // Metastability chain followed by the edge-compare delay flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      dly   <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~dly;
  assign fall  = ~chain[STAGES-1] & dly;

endmodule

// File: rtl/spi_slave_trx_char.sv
// SPI target character transceiver: one 1..32-bit character per frame, all CPOL/CPHA modes, LSB/MSB first.
// Latency: SCK pin edge -> MISO update ~3 S_SYSCLK; last sample edge -> S_RX_VALID ~3 S_SYSCLK.
// Backpressure: none toward the master; one-deep TX holding reg, underrun sends all ones.
// Optional: define SPI_SLV_TX_UNDERRUN_EN for the sticky S_TX_UDR flag and its S_UDR_CLR clear.
module spi_slave_trx_char
  import spi_slave_trx_char_pkg::*;
#(
  parameter int CHAR_NBITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  S_ENABLE,
  input  logic                  S_CPOL,
  input  logic                  S_CPHA,
  input  logic                  S_REV,
  input  logic [3:0]            S_CHAR_LEN,
  input  logic [CHAR_NBITS-1:0] S_WCHAR,
  input  logic                  S_TX_LOAD,
  output logic                  S_TX_READY,
  output logic [CHAR_NBITS-1:0] S_RCHAR,
  output logic                  S_RX_VALID,
  input  logic                  S_SPI_SCK,
  input  logic                  S_SPI_CS_N,
  input  logic                  S_SPI_MOSI,
  output logic                  S_SPI_MISO,
  output logic                  S_SPI_MISO_OE
`ifdef SPI_SLV_TX_UNDERRUN_EN
  ,
  output logic                  S_TX_UDR,
  input  logic                  S_UDR_CLR
`endif
);

  localparam logic [CHAR_NBITS-1:0] ALL_ONES = '1;

  // Synchronized pins and edge strobes
  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_strobes;

  // Sequencer state and frame configuration captured at select
  state_t                state;
  spi_mode_t             cfg_mode;
  logic                  cfg_rev;
  logic [CNT_W-1:0]      cfg_nbits;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      tx_cnt;
  logic [CHAR_NBITS-1:0] tx_word;
  logic [CHAR_NBITS-1:0] rx_acc;
  logic [CHAR_NBITS-1:0] rchar_q;
  logic                  rx_valid_q;
  logic                  miso_q;
  logic                  miso_oe_q;

  // TX holding register
  logic [CHAR_NBITS-1:0] holding;
  logic                  tx_ready_q;

  // Combinational decode
  logic                  selected;
  logic                  lead_stb, trail_stb, sample_stb, shift_stb;
  logic                  select_now, char_end, xfer, load_acc;
  logic [CHAR_NBITS-1:0] tx_src, sel_shift, tx_shift, rx_next;
  logic [CNT_W-1:0]      sel_nbits, sel_idx, rx_idx, tx_idx;

  spi_slave_trx_char_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (S_SYSCLK),
    .rst_n (S_RESETN),
    .pin   (S_SPI_SCK),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_slave_trx_char_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (S_SYSCLK),
    .rst_n (S_RESETN),
    .pin   (S_SPI_CS_N),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_slave_trx_char_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (S_SYSCLK),
    .rst_n (S_RESETN),
    .pin   (S_SPI_MOSI),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // Select is level-based and MOSI is only sampled on SCK strobes, so these go unused
  assign unused_strobes = &{1'b0, sck_lvl, cs_rise, cs_fall, mosi_rise, mosi_fall};

  // Edge classification, transfer events and bit addressing
  always_comb begin
    selected   = S_ENABLE & ~cs_lvl;
    lead_stb   = cfg_mode[1] ? sck_fall : sck_rise;
    trail_stb  = cfg_mode[1] ? sck_rise : sck_fall;
    sample_stb = cfg_mode[0] ? trail_stb : lead_stb;
    shift_stb  = cfg_mode[0] ? lead_stb : trail_stb;
    select_now = (state == ST_IDLE) && selected;
    char_end   = (state == ST_SHIFT) && selected && sample_stb &&
                 (bit_cnt == cfg_nbits - CNT_W'(1));
    xfer       = select_now | char_end;
    load_acc   = S_TX_LOAD & tx_ready_q;
    // Empty holding register feeds all ones to the shifter
    tx_src     = tx_ready_q ? ALL_ONES : holding;
    sel_nbits  = char_bits(S_CHAR_LEN);
    sel_idx    = bit_index(S_REV, sel_nbits, '0);
    sel_shift  = tx_src >> sel_idx;
    rx_idx     = bit_index(cfg_rev, cfg_nbits, bit_cnt);
    rx_next    = rx_acc | (CHAR_NBITS'(mosi_lvl) << rx_idx);
    tx_idx     = bit_index(cfg_rev, cfg_nbits, tx_cnt);
    tx_shift   = tx_word >> tx_idx;
  end

  // Frame sequencer: select/abort, bit counting, MISO drive and character assembly
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      state      <= ST_IDLE;
      cfg_mode   <= MODE0;
      cfg_rev    <= 1'b0;
      cfg_nbits  <= CNT_W'(32);
      bit_cnt    <= '0;
      tx_cnt     <= '0;
      tx_word    <= ALL_ONES;
      rx_acc     <= '0;
      rchar_q    <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b1;
      miso_oe_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso_q    <= 1'b1;
          miso_oe_q <= 1'b0;
          if (selected) begin
            state     <= ST_SHIFT;
            cfg_mode  <= spi_mode_t'({S_CPOL, S_CPHA});
            cfg_rev   <= S_REV;
            cfg_nbits <= sel_nbits;
            tx_word   <= tx_src;
            bit_cnt   <= '0;
            rx_acc    <= '0;
            miso_oe_q <= 1'b1;
            // CPHA=0 masters sample on the first edge, so bit 0 must be out already
            if (S_CPHA) begin
              miso_q <= 1'b1;
              tx_cnt <= '0;
            end else begin
              miso_q <= sel_shift[0];
              tx_cnt <= CNT_W'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (!selected) begin
            // Deselect mid-character drops the partial character silently
            state     <= ST_IDLE;
            miso_q    <= 1'b1;
            miso_oe_q <= 1'b0;
          end else if (sample_stb) begin
            if (char_end) begin
              rchar_q    <= rx_next;
              rx_valid_q <= 1'b1;
              bit_cnt    <= '0;
              rx_acc     <= '0;
              // Reload so the next character can follow without a gap
              tx_word    <= tx_src;
              tx_cnt     <= '0;
            end else begin
              rx_acc  <= rx_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (shift_stb) begin
            miso_q <= (tx_cnt < cfg_nbits) ? tx_shift[0] : 1'b1;
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register: a front-end write lands after any same-cycle transfer
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      holding    <= ALL_ONES;
      tx_ready_q <= 1'b1;
    end else if (load_acc) begin
      holding    <= S_WCHAR;
      tx_ready_q <= 1'b0;
    end else if (xfer) begin
      holding    <= ALL_ONES;
      tx_ready_q <= 1'b1;
    end
  end

`ifdef SPI_SLV_TX_UNDERRUN_EN
  logic udr_q;

  // Sticky underrun: a character loaded from an empty holding register; set beats clear
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN)              udr_q <= 1'b0;
    else if (xfer & tx_ready_q) udr_q <= 1'b1;
    else if (S_UDR_CLR)         udr_q <= 1'b0;
  end

  assign S_TX_UDR = udr_q;
`endif

  assign S_TX_READY    = tx_ready_q;
  assign S_RCHAR       = rchar_q;
  assign S_RX_VALID    = rx_valid_q;
  assign S_SPI_MISO    = miso_q;
  assign S_SPI_MISO_OE = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_trx_char.sv
// Bench for spi_slave_trx_char: bit-banged SPI master plus a character-level model
// (holding register occupancy, expected received characters) and a per-cycle monitor.
module tb_spi_slave_trx_char;

  localparam int H = 4;  // SCK half period in S_SYSCLK cycles

  logic        clk = 1'b0;
  logic        S_RESETN, S_ENABLE, S_CPOL, S_CPHA, S_REV;
  logic [3:0]  S_CHAR_LEN;
  logic [31:0] S_WCHAR;
  logic        S_TX_LOAD, S_TX_READY, S_RX_VALID;
  logic [31:0] S_RCHAR;
  logic        S_SPI_SCK, S_SPI_CS_N, S_SPI_MOSI, S_SPI_MISO, S_SPI_MISO_OE;
`ifdef SPI_SLV_TX_UNDERRUN_EN
  logic        S_TX_UDR, S_UDR_CLR;
`endif

  int checks   = 0;
  int failures = 0;

  // Character-level model
  logic [31:0] m_hold;
  bit          m_full;
  logic [31:0] m_rchar;
  logic [31:0] exp_rx[$];
  int          cs_cnt;
  logic        cs_prev;

  logic [31:0] got, seq;

  spi_slave_trx_char dut (
    .S_SYSCLK      (clk),
    .S_RESETN      (S_RESETN),
    .S_ENABLE      (S_ENABLE),
    .S_CPOL        (S_CPOL),
    .S_CPHA        (S_CPHA),
    .S_REV         (S_REV),
    .S_CHAR_LEN    (S_CHAR_LEN),
    .S_WCHAR       (S_WCHAR),
    .S_TX_LOAD     (S_TX_LOAD),
    .S_TX_READY    (S_TX_READY),
    .S_RCHAR       (S_RCHAR),
    .S_RX_VALID    (S_RX_VALID),
    .S_SPI_SCK     (S_SPI_SCK),
    .S_SPI_CS_N    (S_SPI_CS_N),
    .S_SPI_MOSI    (S_SPI_MOSI),
    .S_SPI_MISO    (S_SPI_MISO),
    .S_SPI_MISO_OE (S_SPI_MISO_OE)
`ifdef SPI_SLV_TX_UNDERRUN_EN
    ,
    .S_TX_UDR      (S_TX_UDR),
    .S_UDR_CLR     (S_UDR_CLR)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_n(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Model: the shifter takes the holding word, or all ones when it is empty
  task automatic take(output logic [31:0] w);
    w      = m_full ? m_hold : 32'hFFFF_FFFF;
    m_full = 1'b0;
  endtask

  task automatic model_reset();
    exp_rx.delete();
    m_full = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    @(negedge clk);
    S_WCHAR   = w;
    S_TX_LOAD = 1'b1;
    if (!m_full) begin
      m_hold = w;
      m_full = 1'b1;
    end
    @(negedge clk);
    S_TX_LOAD = 1'b0;
  endtask

  // One CS frame of nchar characters; optional mid-character abort by CS or by reset
  task automatic frame(input bit cpol, input bit cpha, input bit rev, input logic [3:0] len,
                       input int nchar, input logic [31:0] mo0, input logic [31:0] mo1,
                       input bit do_load1, input logic [31:0] load1,
                       input int abort_bits, input bit rst_abort,
                       output logic [31:0] last_rx, output logic [31:0] last_seq);
    int          n, idx;
    bit          aborted;
    logic        b;
    logic [31:0] txw, mo, rx, sq;
    n = (len == 4'd0) ? 32 : int'(len) + 1;
    aborted  = 1'b0;
    last_rx  = '0;
    last_seq = '0;
    S_CPOL = cpol; S_CPHA = cpha; S_REV = rev; S_CHAR_LEN = len; S_SPI_SCK = cpol;
    repeat (6) @(negedge clk);
    S_SPI_CS_N = 1'b0;
    take(txw);
    repeat (6) @(negedge clk);
    if (do_load1) begin
      check("tx_ready_after_select", 32'(S_TX_READY), 32'd1);
      load_word(load1);
      check("tx_ready_after_load", 32'(S_TX_READY), 32'd0);
    end
    for (int c = 0; c < nchar; c++) begin
      mo = (c == 0) ? mo0 : mo1;
      rx = '0;
      sq = '0;
      if (!(abort_bits >= 0 && c == 0)) exp_rx.push_back(mo & mask_n(n));
      for (int k = 0; k < n; k++) begin
        if (abort_bits >= 0 && c == 0 && k == abort_bits) begin
          aborted = 1'b1;
          break;
        end
        idx = rev ? n - 1 - k : k;
        if (!cpha) begin
          S_SPI_MOSI = mo[idx];
          repeat (H) @(negedge clk);
          S_SPI_SCK = ~cpol;
          b = S_SPI_MISO;
          repeat (H) @(negedge clk);
          S_SPI_SCK = cpol;
        end else begin
          repeat (H) @(negedge clk);
          S_SPI_SCK  = ~cpol;
          S_SPI_MOSI = mo[idx];
          repeat (H) @(negedge clk);
          S_SPI_SCK = cpol;
          b = S_SPI_MISO;
        end
        rx[idx] = b;
        sq = {sq[30:0], b};
      end
      if (aborted) break;
      check("miso_char", rx & mask_n(n), txw & mask_n(n));
      last_rx  = rx;
      last_seq = sq;
      take(txw);
    end
    if (aborted && rst_abort) begin
      repeat (2) @(negedge clk);
      S_RESETN = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_miso", 32'(S_SPI_MISO), 32'd1);
      check("rst_miso_oe", 32'(S_SPI_MISO_OE), 32'd0);
      check("rst_rchar", S_RCHAR, 32'd0);
      check("rst_rx_valid", 32'(S_RX_VALID), 32'd0);
      check("rst_tx_ready", 32'(S_TX_READY), 32'd1);
`ifdef SPI_SLV_TX_UNDERRUN_EN
      check("rst_tx_udr", 32'(S_TX_UDR), 32'd0);
`endif
      S_SPI_CS_N = 1'b1;
      repeat (3) @(negedge clk);
      S_RESETN = 1'b1;
    end else if (aborted) begin
      S_SPI_CS_N = 1'b1;
      repeat (4) @(negedge clk);
      check("miso_oe_after_abort", 32'(S_SPI_MISO_OE), 32'd0);
    end else begin
      repeat (H) @(negedge clk);
      S_SPI_CS_N = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  // Monitor: received characters in order, RCHAR stable between pulses, OE follows CS
  always @(negedge clk) begin
    if (S_SPI_CS_N !== cs_prev) cs_cnt = 0;
    else if (cs_cnt < 1000)     cs_cnt++;
    cs_prev = S_SPI_CS_N;
    if (!S_RESETN) begin
      m_rchar = '0;
    end else begin
      if (S_RX_VALID) begin
        check("rx_valid_expected", 32'(exp_rx.size() > 0), 32'd1);
        if (exp_rx.size() > 0) m_rchar = exp_rx.pop_front();
      end
      check("rchar_track", S_RCHAR, m_rchar);
      if (cs_cnt == 4) check("miso_oe_vs_cs", 32'(S_SPI_MISO_OE), 32'(!S_SPI_CS_N));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    S_RESETN = 1'b0; S_ENABLE = 1'b1; S_CPOL = 1'b0; S_CPHA = 1'b0; S_REV = 1'b0;
    S_CHAR_LEN = 4'd7; S_WCHAR = '0; S_TX_LOAD = 1'b0;
    S_SPI_SCK = 1'b0; S_SPI_CS_N = 1'b1; S_SPI_MOSI = 1'b0;
`ifdef SPI_SLV_TX_UNDERRUN_EN
    S_UDR_CLR = 1'b0;
`endif
    m_full = 1'b0; m_hold = '0; m_rchar = '0; cs_cnt = 0; cs_prev = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_miso", 32'(S_SPI_MISO), 32'd1);
    check("reset_miso_oe", 32'(S_SPI_MISO_OE), 32'd0);
    check("reset_rchar", S_RCHAR, 32'd0);
    check("reset_rx_valid", 32'(S_RX_VALID), 32'd0);
    check("reset_tx_ready", 32'(S_TX_READY), 32'd1);
    S_RESETN = 1'b1;
    repeat (5) @(negedge clk);

    // 1: mode 0, 8 bits, MSB first
    load_word(32'hA5);
    frame(1'b0, 1'b0, 1'b1, 4'd7, 1, 32'h3C, 32'h0, 1'b0, 32'h0, -1, 1'b0, got, seq);
    check("t1_miso_bit_order", seq & 32'hFF, 32'b10100101);
    check("t1_rchar", S_RCHAR, 32'h3C);
    check("t1_rx_count", 32'(exp_rx.size()), 32'd0);

    // 2: mode 3, 32 bits, LSB first
    load_word(32'hDEADBEEF);
    frame(1'b1, 1'b1, 1'b0, 4'd0, 1, 32'h12345678, 32'h0, 1'b0, 32'h0, -1, 1'b0, got, seq);
    check("t2_master_rx", got, 32'hDEADBEEF);
    check("t2_rchar", S_RCHAR, 32'h12345678);

    // 3: modes 1 and 2, two 16-bit characters under one CS
    load_word(32'h1234);
    frame(1'b0, 1'b1, 1'b0, 4'd15, 2, 32'hA55A, 32'h0FF0, 1'b1, 32'hBEEF, -1, 1'b0, got, seq);
    check("t3a_second_char", got, 32'hBEEF);
    check("t3a_rchar", S_RCHAR, 32'h0FF0);
    check("t3a_tx_ready", 32'(S_TX_READY), 32'd1);
    load_word(32'h8001);
    frame(1'b1, 1'b0, 1'b1, 4'd15, 2, 32'h1357, 32'hFACE, 1'b1, 32'h7E11, -1, 1'b0, got, seq);
    check("t3b_second_char", got, 32'h7E11);
    check("t3b_rchar", S_RCHAR, 32'hFACE);
    check("t3_rx_count", 32'(exp_rx.size()), 32'd0);

    // 4: underrun, nothing loaded
`ifdef SPI_SLV_TX_UNDERRUN_EN
    @(negedge clk); S_UDR_CLR = 1'b1; @(negedge clk); S_UDR_CLR = 1'b0;
    check("t4_udr_cleared", 32'(S_TX_UDR), 32'd0);
`endif
    frame(1'b0, 1'b0, 1'b0, 4'd7, 1, 32'h81, 32'h0, 1'b0, 32'h0, -1, 1'b0, got, seq);
    check("t4_underrun_ones", got & 32'hFF, 32'hFF);
    check("t4_rchar", S_RCHAR, 32'h81);
`ifdef SPI_SLV_TX_UNDERRUN_EN
    check("t4_udr_set", 32'(S_TX_UDR), 32'd1);
    @(negedge clk); S_UDR_CLR = 1'b1; @(negedge clk); S_UDR_CLR = 1'b0;
    check("t4_udr_clr", 32'(S_TX_UDR), 32'd0);
`endif

    // 5: CS abort after 5 of 8 bits
    load_word(32'h5A);
    frame(1'b0, 1'b0, 1'b0, 4'd7, 1, 32'h96, 32'h0, 1'b0, 32'h0, 5, 1'b0, got, seq);
    check("t5_rchar_kept", S_RCHAR, 32'h81);
    check("t5_no_rx", 32'(exp_rx.size()), 32'd0);

    // 6: reset mid-character, then a clean frame
    load_word(32'h3C);
    frame(1'b0, 1'b0, 1'b0, 4'd7, 1, 32'h55, 32'h0, 1'b0, 32'h0, 3, 1'b1, got, seq);
    repeat (4) @(negedge clk);
    load_word(32'hC3);
    frame(1'b0, 1'b0, 1'b0, 4'd7, 1, 32'h66, 32'h0, 1'b0, 32'h0, -1, 1'b0, got, seq);
    check("t6_master_rx", got & 32'hFF, 32'hC3);
    check("t6_rchar", S_RCHAR, 32'h66);
    check("t6_rx_count", 32'(exp_rx.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
